patient_admission_ctrl: RTL and testbench
=========================================

// Module: patient_admission_ctrl
// PURPOSE
//  Admission-desk front end (writer) for the emergency-room priority queue.
//  - Accepts patient arrivals carrying a triage priority and assigns a rolling unique ID.
//  - Tracks room occupancy and issues single-cycle enqueue words {priority, ID} to the queue.
//  - When the room is full, holds the arrival until a discharge frees a slot, or rejects it after a timeout.
// PARAMETERS
//  CAPACITY      15  max patients in room; enqueue never issued when occupancy==CAPACITY
//  OCC_W          4  occupancy counter width; CAPACITY must be <= 2**OCC_W-1
//  PRI_W          2  priority width (higher value = more urgent)
//  ID_W           2  patient ID width; ID counter wraps modulo 2**ID_W
//  HOLD_TIMEOUT   8  max cycles an arrival waits in HOLD before rejection (>=1)
//  ESC_PERIOD     4  HOLD cycles per priority escalation step (used only with ADMIT_ESCALATE_EN)
// PORTS
//  clk          in   1            system clock, rising edge
//  rst          in   1            asynchronous reset, active-high
//  arr_valid    in   1            arrival present this cycle
//  arr_priority in   PRI_W        triage priority of the arrival
//  arr_ready    out  1            desk can accept an arrival (state IDLE and rst low)
//  q_deq        in   1            one-cycle pulse: queue dequeued a patient to the doctor
//  q_wr_en      out  1            one-cycle enqueue strobe to the queue
//  q_data       out  PRI_W+ID_W   enqueue word {priority, id}; priority in MSBs
//  occupancy    out  OCC_W        patients currently in the room
//  is_full      out  1            occupancy==CAPACITY
//  is_empty     out  1            occupancy==0
//  reject       out  1            one-cycle pulse: held arrival timed out and was dropped
//  underflow    out  1            sticky flag: q_deq received while occupancy==0
// BEHAVIOUR
//  - Reset (async, rst high): state=IDLE, occupancy=0, next_id=0, q_wr_en=0, q_data=0,
//    reject=0, underflow=0, is_empty=1, is_full=0. arr_ready=0 while rst is high.
//  - States: IDLE, HOLD, ISSUE. All outputs except arr_ready are registered.
//  - IDLE: arr_ready=1. Accept on arr_valid&arr_ready; latch pri=arr_priority.
//    If slot free (occupancy<CAPACITY, or q_deq in the same cycle) -> ISSUE, else -> HOLD with timer=0.
//  - ISSUE (one cycle): q_wr_en=1, q_data={pri,next_id}. next_id<=next_id+1, wrapping to 0. Then -> IDLE.
//    The arrival accepted in cycle N is enqueued in cycle N+1 when a slot is free.
//  - HOLD: arr_ready=0; timer increments each cycle.
//    If q_deq, or occupancy<CAPACITY -> ISSUE.
//    Otherwise, when timer==HOLD_TIMEOUT-1 -> reject=1 for one cycle, go to IDLE; next_id is not consumed.
//    q_deq takes precedence over timeout in the same cycle.
//  - Occupancy update each cycle:
//    +1 when q_wr_en is issued, -1 on q_deq with occupancy>0.
//    Issue and q_deq in the same cycle -> net 0.
//    q_deq at occupancy 0 -> occupancy stays 0 and underflow is set; only rst clears underflow.
//  - is_full/is_empty are registered and consistent with occupancy in the same cycle.
//  - arr_valid while arr_ready=0 is ignored; nothing is latched.
//  - rst mid-HOLD or mid-ISSUE: the pending arrival is discarded with no q_wr_en and no reject.
// CONFIGURATION
//  ADMIT_ESCALATE_EN defined:
//    - In HOLD, every ESC_PERIOD cycles the latched pri increments, saturating at 2**PRI_W-1.
//    - The escalated value is the one sent in q_data.
//  ADMIT_ESCALATE_EN undefined:
//    - pri is unchanged from acceptance to enqueue; ESC_PERIOD is unused.
// TESTING
//  1. Reset, then arr_valid with priority 2 -> q_wr_en in the next cycle, q_data=4'b1000, occupancy=1, is_empty=0.
//  2. 15 admissions with no q_deq -> occupancy=15, is_full=1; IDs wrap 0,1,2,3,0...
//     16th arrival -> HOLD, arr_ready=0; after 8 cycles reject pulses, occupancy stays 15.
//  3. Full room, arrival enters HOLD, q_deq on cycle 3 -> ISSUE next cycle, occupancy stays 15, no reject.
//  4. q_deq coincident with ISSUE at occupancy 5 -> occupancy stays 5.
//     q_deq at occupancy 0 -> underflow=1, occupancy=0.
//  5. rst asserted during HOLD -> all outputs at reset values immediately; no q_wr_en after release.
//  6. ADMIT_ESCALATE_EN, full room, priority-0 arrival, q_deq after 9 HOLD cycles -> q_data priority=2.
//     Without ADMIT_ESCALATE_EN, the same stimulus gives priority 0 (HOLD_TIMEOUT=16 for this case).

Source files
------------

// File: rtl/patient_admission_ctrl.sv
// Admission desk: accepts triage arrivals, assigns rolling IDs and issues enqueue words to the ER queue.
// Optional build macro ADMIT_ESCALATE_EN raises the held arrival's priority every ESC_PERIOD HOLD cycles.
module patient_admission_ctrl #(
  parameter int CAPACITY     = 15,
  parameter int OCC_W        = 4,
  parameter int PRI_W        = 2,
  parameter int ID_W         = 2,
  parameter int HOLD_TIMEOUT = 8,
  parameter int ESC_PERIOD   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arr_valid,
  input  logic [PRI_W-1:0]      arr_priority,
  output logic                  arr_ready,
  input  logic                  q_deq,
  output logic                  q_wr_en,
  output logic [PRI_W+ID_W-1:0] q_data,
  output logic [OCC_W-1:0]      occupancy,
  output logic                  is_full,
  output logic                  is_empty,
  output logic                  reject,
  output logic                  underflow
);

  localparam int TMR_W = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
  localparam logic [OCC_W-1:0] CAP_V    = OCC_W'(CAPACITY);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_ZERO = OCC_W'(0);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(HOLD_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, ISSUE = 2'd2} state_t;

  state_t              state, next_state;
  logic [TMR_W-1:0]    timer, next_timer;
  logic [PRI_W-1:0]    pri, next_pri;
  logic [ID_W-1:0]     next_id;
  logic                next_wr, next_reject, slot_free;
  logic [OCC_W-1:0]    occ_inc, occ_dec, occ_next;

`ifdef ADMIT_ESCALATE_EN
  localparam int ESC_W = (ESC_PERIOD > 1) ? $clog2(ESC_PERIOD) : 1;
  localparam logic [ESC_W-1:0] ESC_LAST = ESC_W'(ESC_PERIOD - 1);
  localparam logic [PRI_W-1:0] PRI_MAX  = {PRI_W{1'b1}};
  logic [ESC_W-1:0] esc_cnt, next_esc;
`endif

  assign arr_ready = (state == IDLE) && !rst;
  assign slot_free = (occupancy < CAP_V) || q_deq;

  // Next-state, enqueue strobe and hold-timer decisions.
  always_comb begin
    next_state  = state;
    next_timer  = timer;
    next_pri    = pri;
    next_wr     = 1'b0;
    next_reject = 1'b0;
`ifdef ADMIT_ESCALATE_EN
    next_esc    = esc_cnt;
`endif
    case (state)
      IDLE: begin
        if (arr_valid) begin
          next_pri   = arr_priority;
          next_timer = '0;
`ifdef ADMIT_ESCALATE_EN
          next_esc   = '0;
`endif
          if (slot_free) begin
            next_state = ISSUE;
            next_wr    = 1'b1;
          end else begin
            next_state = HOLD;
          end
        end else begin
          next_state = IDLE;
        end
      end
      HOLD: begin
        // A freed slot wins over a timeout landing in the same cycle.
        if (slot_free) begin
          next_state = ISSUE;
          next_wr    = 1'b1;
        end else if (timer == TMR_LAST) begin
          next_state  = IDLE;
          next_reject = 1'b1;
        end else begin
          next_timer = timer + TMR_ONE;
`ifdef ADMIT_ESCALATE_EN
          if (esc_cnt == ESC_LAST) begin
            next_esc = '0;
            next_pri = (pri == PRI_MAX) ? pri : pri + PRI_W'(1);
          end else begin
            next_esc = esc_cnt + ESC_W'(1);
          end
`endif
        end
      end
      ISSUE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Occupancy moves on the issue cycle and on a dequeue from a non-empty room.
  always_comb begin
    occ_inc  = (state == ISSUE) ? OCC_ONE : OCC_ZERO;
    occ_dec  = (q_deq && (occupancy != OCC_ZERO)) ? OCC_ONE : OCC_ZERO;
    occ_next = occupancy + occ_inc - occ_dec;
  end

  // State, latched arrival and hold timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      pri   <= '0;
    end else begin
      state <= next_state;
      timer <= next_timer;
      pri   <= next_pri;
    end
  end

`ifdef ADMIT_ESCALATE_EN
  // Escalation step counter, only present in the escalating build.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) esc_cnt <= '0;
    else     esc_cnt <= next_esc;
  end
`endif

  // Registered outputs, ID counter and room bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_wr_en   <= 1'b0;
      q_data    <= '0;
      reject    <= 1'b0;
      next_id   <= '0;
      occupancy <= '0;
      is_full   <= 1'b0;
      is_empty  <= 1'b1;
      underflow <= 1'b0;
    end else begin
      q_wr_en   <= next_wr;
      reject    <= next_reject;
      q_data    <= next_wr ? {next_pri, next_id} : q_data;
      next_id   <= (state == ISSUE) ? next_id + ID_W'(1) : next_id;
      occupancy <= occ_next;
      is_full   <= (occ_next == CAP_V);
      is_empty  <= (occ_next == OCC_ZERO);
      underflow <= underflow | (q_deq && (occupancy == OCC_ZERO));
    end
  end

endmodule

// File: tb/tb_patient_admission_ctrl.sv
// Directed bench for patient_admission_ctrl: dut 0 uses HOLD_TIMEOUT=8, dut 1 uses HOLD_TIMEOUT=16.
module tb_patient_admission_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       arr_valid [2];
  logic [1:0] arr_priority [2];
  logic       q_deq [2];
  logic       arr_ready [2];
  logic       q_wr_en [2];
  logic [3:0] q_data [2];
  logic [3:0] occupancy [2];
  logic       is_full [2];
  logic       is_empty [2];
  logic       reject [2];
  logic       underflow [2];

  int total = 0;
  int bad = 0;
  logic [1:0] exp_id;

  always #5 clk = ~clk;

  patient_admission_ctrl #(.HOLD_TIMEOUT(8)) u_dut0 (
    .clk(clk), .rst(rst), .arr_valid(arr_valid[0]), .arr_priority(arr_priority[0]),
    .arr_ready(arr_ready[0]), .q_deq(q_deq[0]), .q_wr_en(q_wr_en[0]), .q_data(q_data[0]),
    .occupancy(occupancy[0]), .is_full(is_full[0]), .is_empty(is_empty[0]),
    .reject(reject[0]), .underflow(underflow[0]));

  patient_admission_ctrl #(.HOLD_TIMEOUT(16)) u_dut1 (
    .clk(clk), .rst(rst), .arr_valid(arr_valid[1]), .arr_priority(arr_priority[1]),
    .arr_ready(arr_ready[1]), .q_deq(q_deq[1]), .q_wr_en(q_wr_en[1]), .q_data(q_data[1]),
    .occupancy(occupancy[1]), .is_full(is_full[1]), .is_empty(is_empty[1]),
    .reject(reject[1]), .underflow(underflow[1]));

  // Stimulus only: present one arrival at a negedge, report what the issue cycle shows.
  task automatic admit(input int d, input logic [1:0] p, output logic wr, output logic [3:0] data);
    arr_valid[d] = 1'b1;
    arr_priority[d] = p;
    @(negedge clk);
    wr = q_wr_en[d];
    data = q_data[d];
    arr_valid[d] = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    for (int d = 0; d < 2; d++) begin
      arr_valid[d] = 1'b0; arr_priority[d] = 2'd0; q_deq[d] = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      arr_valid[d] = 1'b0; arr_priority[d] = 2'd0; q_deq[d] = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    total++; if (arr_ready[0] !== 1'b0) begin bad++; $display("FAIL reset_arr_ready got=%b exp=0", arr_ready[0]); end
    total++; if ({q_wr_en[0], q_data[0], occupancy[0], is_full[0], is_empty[0], reject[0], underflow[0]} !== 13'b0_0000_0000_0100) begin
      bad++; $display("FAIL reset_outputs got wr=%b data=%h occ=%0d full=%b empty=%b rej=%b unf=%b exp all 0 except empty=1",
        q_wr_en[0], q_data[0], occupancy[0], is_full[0], is_empty[0], reject[0], underflow[0]);
    end
    rst = 1'b0;
    @(negedge clk);
    total++; if (arr_ready[0] !== 1'b1) begin bad++; $display("FAIL idle_arr_ready got=%b exp=1", arr_ready[0]); end
  endtask

  task automatic test_first_admit();
    arr_valid[0] = 1'b1; arr_priority[0] = 2'd2;
    @(negedge clk);
    arr_valid[0] = 1'b0;
    total++; if ({q_wr_en[0], q_data[0]} !== 5'b1_1000) begin bad++; $display("FAIL first_issue got wr=%b data=%b exp wr=1 data=1000", q_wr_en[0], q_data[0]); end
    @(negedge clk);
    total++; if ({q_wr_en[0], occupancy[0], is_empty[0]} !== 6'b0_0001_0) begin bad++; $display("FAIL first_occ got wr=%b occ=%0d empty=%b exp 0/1/0", q_wr_en[0], occupancy[0], is_empty[0]); end
    exp_id = 2'd1;
  endtask

  task automatic test_fill_and_timeout();
    logic wr; logic [3:0] data; int errs;
    errs = 0;
    for (int i = 1; i < 15; i++) begin
      admit(0, 2'(i), wr, data);
      if ({wr, data} !== {1'b1, 2'(i), exp_id}) errs++;
      exp_id = exp_id + 2'd1;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL fill_ids got errors=%0d exp=0", errs); end
    total++; if ({occupancy[0], is_full[0]} !== 5'b1111_1) begin bad++; $display("FAIL full_state got occ=%0d full=%b exp 15/1", occupancy[0], is_full[0]); end
    arr_valid[0] = 1'b1; arr_priority[0] = 2'd3;
    @(negedge clk);
    arr_valid[0] = 1'b0;
    total++; if (arr_ready[0] !== 1'b0) begin bad++; $display("FAIL hold_arr_ready got=%b exp=0", arr_ready[0]); end
    errs = 0;
    for (int k = 0; k < 8; k++) begin
      if (reject[0] !== 1'b0 || q_wr_en[0] !== 1'b0) errs++;
      @(negedge clk);
    end
    total++; if (errs != 0) begin bad++; $display("FAIL hold_early_reject got errors=%0d exp=0", errs); end
    total++; if ({reject[0], occupancy[0]} !== 5'b1_1111) begin bad++; $display("FAIL timeout_reject got rej=%b occ=%0d exp 1/15", reject[0], occupancy[0]); end
    @(negedge clk);
    total++; if ({reject[0], arr_ready[0]} !== 2'b01) begin bad++; $display("FAIL reject_pulse got rej=%b ready=%b exp 0/1", reject[0], arr_ready[0]); end
  endtask

  task automatic test_hold_release();
    arr_valid[0] = 1'b1; arr_priority[0] = 2'd1;
    @(negedge clk);
    arr_valid[0] = 1'b0;
    @(negedge clk); @(negedge clk);
    q_deq[0] = 1'b1;
    @(negedge clk);
    q_deq[0] = 1'b0;
    total++; if ({q_wr_en[0], q_data[0], reject[0], occupancy[0]} !== {1'b1, 2'd1, exp_id, 1'b0, 4'd14}) begin
      bad++; $display("FAIL hold_release got wr=%b data=%b rej=%b occ=%0d exp 1/01%b/0/14", q_wr_en[0], q_data[0], reject[0], occupancy[0], exp_id);
    end
    exp_id = exp_id + 2'd1;
    @(negedge clk);
    total++; if ({reject[0], occupancy[0]} !== 5'b0_1111) begin bad++; $display("FAIL hold_release_occ got rej=%b occ=%0d exp 0/15", reject[0], occupancy[0]); end
  endtask

  task automatic test_back_to_back();
    q_deq[0] = 1'b1;
    repeat (10) @(negedge clk);
    q_deq[0] = 1'b0;
    total++; if (occupancy[0] !== 4'd5) begin bad++; $display("FAIL drain_to_5 got occ=%0d exp=5", occupancy[0]); end
    arr_valid[0] = 1'b1; arr_priority[0] = 2'd3;
    @(negedge clk);
    arr_valid[0] = 1'b0; q_deq[0] = 1'b1;
    total++; if ({q_wr_en[0], q_data[0]} !== {1'b1, 2'd3, exp_id}) begin bad++; $display("FAIL issue_with_deq got wr=%b data=%b exp 1/11%b", q_wr_en[0], q_data[0], exp_id); end
    @(negedge clk);
    q_deq[0] = 1'b0;
    total++; if (occupancy[0] !== 4'd5) begin bad++; $display("FAIL net_zero got occ=%0d exp=5", occupancy[0]); end
    q_deq[0] = 1'b1;
    repeat (5) @(negedge clk);
    total++; if ({occupancy[0], is_empty[0], underflow[0]} !== 6'b0000_1_0) begin bad++; $display("FAIL drain_empty got occ=%0d empty=%b unf=%b exp 0/1/0", occupancy[0], is_empty[0], underflow[0]); end
    @(negedge clk);
    q_deq[0] = 1'b0;
    total++; if ({occupancy[0], underflow[0]} !== 5'b0000_1) begin bad++; $display("FAIL underflow_set got occ=%0d unf=%b exp 0/1", occupancy[0], underflow[0]); end
    @(negedge clk);
    total++; if (underflow[0] !== 1'b1) begin bad++; $display("FAIL underflow_sticky got=%b exp=1", underflow[0]); end
  endtask

  task automatic test_reset_in_hold();
    logic wr; logic [3:0] data; int errs;
    do_reset();
    for (int i = 0; i < 15; i++) admit(0, 2'd0, wr, data);
    arr_valid[0] = 1'b1; arr_priority[0] = 2'd2;
    @(negedge clk);
    arr_valid[0] = 1'b0;
    @(negedge clk); @(negedge clk);
    #3 rst = 1'b1;
    #1;
    total++; if ({arr_ready[0], q_wr_en[0], q_data[0], occupancy[0], is_full[0], is_empty[0], reject[0], underflow[0]} !== 14'b0_0_0000_0000_0_1_0_0) begin
      bad++; $display("FAIL async_reset got ready=%b wr=%b data=%h occ=%0d full=%b empty=%b rej=%b unf=%b exp reset values",
        arr_ready[0], q_wr_en[0], q_data[0], occupancy[0], is_full[0], is_empty[0], reject[0], underflow[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    errs = 0;
    repeat (12) begin
      @(negedge clk);
      if (q_wr_en[0] !== 1'b0 || reject[0] !== 1'b0) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL post_reset_quiet got errors=%0d exp=0", errs); end
  endtask

  task automatic test_escalate();
    logic wr; logic [3:0] data; logic [1:0] exp_pri;
`ifdef ADMIT_ESCALATE_EN
    exp_pri = 2'd2;
`else
    exp_pri = 2'd0;
`endif
    for (int i = 0; i < 15; i++) admit(1, 2'd0, wr, data);
    arr_valid[1] = 1'b1; arr_priority[1] = 2'd0;
    @(negedge clk);
    arr_valid[1] = 1'b0;
    total++; if (arr_ready[1] !== 1'b0) begin bad++; $display("FAIL esc_hold got ready=%b exp=0", arr_ready[1]); end
    repeat (9) @(negedge clk);
    q_deq[1] = 1'b1;
    @(negedge clk);
    q_deq[1] = 1'b0;
    total++; if ({q_wr_en[1], q_data[1]} !== {1'b1, exp_pri, 2'd3}) begin bad++; $display("FAIL esc_priority got wr=%b data=%b exp 1/%b11", q_wr_en[1], q_data[1], exp_pri); end
  endtask

  initial begin
    test_reset();
    test_first_admit();
    test_fill_and_timeout();
    test_hold_release();
    test_back_to_back();
    test_reset_in_hold();
    test_escalate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
